load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 21 ++
 rtl/load_store_unit_if.sv | 12 +
 rtl/load_store_unit_align.sv | 21 ++
 rtl/load_store_unit.sv | 89 ++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 codes, FSM encoding and byte-enable masks shared by the LSU
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  // unsigned widths are load-only, so a store with BU/HU is rejected like an unknown code
  function automatic logic req_bad(logic we, logic [2:0] f3, logic [1:0] a);
    logic legal;
    legal = f3 == F3_B || f3 == F3_H || f3 == F3_W || (!we && (f3 == F3_BU || f3 == F3_HU));
    return !legal || ((f3 == F3_H || f3 == F3_HU) && a[0]) || (f3 == F3_W && a != 2'b00);
  endfunction
  function automatic logic [3:0] be_of(logic [2:0] f3, logic [1:0] a);
    return f3 == F3_W ? BE_W : (f3[1:0] == 2'b01 ? BE_H : BE_B) << a;
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory bus between the LSU (master) and memory (slave)
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: picks the addressed byte/half lane of a read word and sign/zero extends it
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = mem_rdata[{off, 3'b000} +: 8];
    h = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    rdata = funct3 == F3_B  ? {{24{b[7]}}, b} :
            funct3 == F3_BU ? {24'b0, b} :
            funct3 == F3_H  ? {{16{h[15]}}, h} :
            funct3 == F3_HU ? {16'b0, h} :
            funct3 == F3_W  ? mem_rdata : '0;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RISC-V load/store engine with alignment, extension and bus timeout
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  load_store_unit_if.master mem
);
  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, ld_data;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        take, bad_start, timeout, acc, acc_end;

  lsu_align u_align (.mem_rdata(mem.mem_rdata), .off(addr_q[1:0]), .funct3(f3_q), .rdata(ld_data));

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;

  always_comb begin
    acc = state_q == S_ACCESS;
    take = state_q == S_IDLE && start;
    bad_start = take && req_bad(we, funct3, addr[1:0]);
    timeout = cnt_q == 8'(TIMEOUT - 1);
    acc_end = acc && (mem.mem_ack || timeout);
    state_d = take ? (bad_start ? S_DONE : S_ACCESS) :
              state_q == S_IDLE ? S_IDLE :
              acc ? (acc_end ? S_DONE : S_ACCESS) : S_IDLE;
  end

  always_comb begin
    we_d = take ? we : we_q;
    f3_d = take ? funct3 : f3_q;
    addr_d = take ? addr : addr_q;
    wdata_d = take ? wdata : wdata_q;
    cnt_d = acc ? cnt_q + 8'd1 : 8'd0;
    // an ack in the last timeout cycle still counts as a normal completion
    err_d = bad_start ? 1'b1 : acc_end ? !mem.mem_ack : err_q;
    rdata_d = bad_start ? '0 : acc_end ? (mem.mem_ack && !we_q ? ld_data : '0) : rdata_q;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      we_q <= we_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end

  // bus fields are forced to zero outside ACCESS so reset clears them without a clock
  always_comb begin
    busy = state_q != S_IDLE;
    done = state_q == S_DONE;
    err = err_q;
    rdata = rdata_q;
    mem.mem_req = acc;
    mem.mem_we = acc && we_q;
    mem.mem_addr = acc ? {addr_q[31:2], 2'b00} : '0;
    mem.mem_be = acc ? be_of(f3_q, addr_q[1:0]) : '0;
    mem.mem_wdata = !acc ? '0 :
                    f3_q == F3_B ? {4{wdata_q[7:0]}} :
                    f3_q == F3_H ? {2{wdata_q[15:0]}} : wdata_q;
  end
endmodule
